// File: rtl/kpn_pkg.sv
// Shared definitions for KPN process nodes: token width default, FSM encoding, token type.
`default_nettype none

package kpn_pkg;

    localparam int BITS_NUMBER_DEF = 16;
    localparam int COUNT_BITS_DEF  = 16;

    localparam logic ST_READ  = 1'b0;
    localparam logic ST_WRITE = 1'b1;

    typedef enum logic {
        S_READ  = ST_READ,
        S_WRITE = ST_WRITE
    } state_e;

    typedef logic [BITS_NUMBER_DEF-1:0] token_t;

endpackage

`default_nettype wire

// File: rtl/kpn_adder_process_if.sv
// Queue-side bundle of the adder process: two show-ahead input queues, one output queue, status.
`default_nettype none

interface kpn_adder_process_if #(
    parameter int BITS_NUMBER = 16,
    parameter int COUNT_BITS  = 16
) ();

    logic [BITS_NUMBER-1:0] entry_1;
    logic [BITS_NUMBER-1:0] entry_2;
    logic                   empty_1;
    logic                   empty_2;
    logic                   rd_1;
    logic                   rd_2;
    logic                   full_out;
    logic [BITS_NUMBER-1:0] output_1;
    logic                   wr_1;
    logic [COUNT_BITS-1:0]  tokens_count;
    logic                   busy;

    // master: the queue environment around the process
    modport master (
        output entry_1, entry_2, empty_1, empty_2, full_out,
        input  rd_1, rd_2, output_1, wr_1, tokens_count, busy
    );

    // slave: the adder process itself
    modport slave (
        input  entry_1, entry_2, empty_1, empty_2, full_out,
        output rd_1, rd_2, output_1, wr_1, tokens_count, busy
    );

endinterface

`default_nettype wire

// File: rtl/kpn_adder_process.sv
// Kahn process node: pops one token from each input queue, pushes their modular sum downstream.
`default_nettype none

module kpn_adder_process
    import kpn_pkg::*;
#(
    parameter int BITS_NUMBER = BITS_NUMBER_DEF,
    parameter int COUNT_BITS  = COUNT_BITS_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    kpn_adder_process_if.slave bus
);

    state_e                 state_q, state_d;
    logic [BITS_NUMBER-1:0] sum_q, sum_d;
    logic [COUNT_BITS-1:0]  count_q, count_d;
    logic                   rd_d;
    logic                   wr_d;
    logic                   busy_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_READ;
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    // reset_n gates the pop strobe so nothing is popped while reset is held
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            S_READ: begin
                if (reset_n && !bus.empty_1 && !bus.empty_2) begin
                    rd_d    = 1'b1;
                    sum_d   = bus.entry_1 + bus.entry_2;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy_d = 1'b1;
                if (!bus.full_out) begin
                    wr_d    = 1'b1;
                    count_d = count_q + COUNT_BITS'(1);
                    state_d = S_READ;
                end
            end
            default: state_d = S_READ;
        endcase
    end

    assign bus.rd_1         = rd_d;
    assign bus.rd_2         = rd_d;
    assign bus.wr_1         = wr_d;
    assign bus.busy         = busy_d;
    assign bus.output_1     = sum_q;
    assign bus.tokens_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_kpn_adder_process.sv
// Self-checking bench for kpn_adder_process: token-level queue model plus directed vectors.
`default_nettype none

module tb_kpn_adder_process;

    localparam int BW = 16;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    kpn_adder_process_if #(.BITS_NUMBER(BW), .COUNT_BITS(CW)) bus ();

    kpn_adder_process #(.BITS_NUMBER(BW), .COUNT_BITS(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] q1[$];
    logic [BW-1:0] q2[$];
    logic [BW-1:0] push_log[$];
    logic [CW-1:0] cnt_log[$];
    bit            pop_pending = 0;
    int            rd_pulses = 0;

    // Token-level model state
    bit            m_hold = 0;
    logic [BW-1:0] m_out  = '0;
    logic [CW-1:0] m_cnt  = '0;
    bit            prev_wr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Show-ahead queue drivers: heads and empty flags change just after the clock edge
    initial begin
        bus.entry_1  = '0;
        bus.entry_2  = '0;
        bus.empty_1  = 1'b1;
        bus.empty_2  = 1'b1;
        bus.full_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pop_pending) begin
                if (q1.size() > 0) void'(q1.pop_front());
                if (q2.size() > 0) void'(q2.pop_front());
                pop_pending = 0;
            end
            bus.empty_1 = (q1.size() == 0);
            bus.empty_2 = (q2.size() == 0);
            bus.entry_1 = (q1.size() > 0) ? q1[0] : '0;
            bus.entry_2 = (q2.size() > 0) ? q2[0] : '0;
        end
    end

    // Compare process: every cycle, check DUT against the token-level model
    initial begin
        bit            exp_rd;
        bit            exp_wr;
        logic [BW-1:0] s;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_rd_1", 32'(bus.rd_1), 0);
                chk("rst_rd_2", 32'(bus.rd_2), 0);
                chk("rst_wr_1", 32'(bus.wr_1), 0);
                chk("rst_busy", 32'(bus.busy), 0);
                chk("rst_output_1", 32'(bus.output_1), 0);
                chk("rst_tokens_count", 32'(bus.tokens_count), 0);
                m_hold = 0; m_out = '0; m_cnt = '0; prev_wr = 0; pop_pending = 0;
            end else begin
                if (prev_wr) cnt_log.push_back(bus.tokens_count);
                exp_rd = !m_hold && !bus.empty_1 && !bus.empty_2;
                exp_wr = m_hold && !bus.full_out;
                chk("rd_1", 32'(bus.rd_1), 32'(exp_rd));
                chk("rd_2", 32'(bus.rd_2), 32'(exp_rd));
                chk("wr_1", 32'(bus.wr_1), 32'(exp_wr));
                chk("busy", 32'(bus.busy), 32'(m_hold));
                chk("output_1", 32'(bus.output_1), 32'(m_out));
                chk("tokens_count", 32'(bus.tokens_count), 32'(m_cnt));
                prev_wr = exp_wr;
                if (exp_wr) begin
                    push_log.push_back(bus.output_1);
                    m_cnt  = m_cnt + 1'b1;
                    m_hold = 0;
                end else if (exp_rd) begin
                    s = bus.entry_1 + bus.entry_2;
                    m_out = s;
                    m_hold = 1;
                    pop_pending = 1;
                    rd_pulses++;
                end
            end
        end
    end

    task automatic push_pair(input logic [BW-1:0] a, input logic [BW-1:0] b);
        @(posedge clk);
        #2;
        q1.push_back(a);
        q2.push_back(b);
    endtask

    task automatic wait_pushes(input int n, input int budget, input string name);
        int k = 0;
        while (push_log.size() < n && k < budget) begin
            @(posedge clk);
            #3;
            k++;
        end
        if (push_log.size() < n) chk({name, "_timeout"}, 32'(push_log.size()), 32'(n));
    endtask

    task automatic wait_busy(input int budget, input string name);
        int k = 0;
        while (!bus.busy && k < budget) begin
            @(posedge clk);
            #3;
            k++;
        end
        chk({name, "_busy"}, 32'(bus.busy), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #3;
        chk("reset_tokens_count", 32'(bus.tokens_count), 0);
        chk("reset_output_1", 32'(bus.output_1), 0);

        // Two sums back to back: 3+4, 5+10
        push_log.delete(); rd_pulses = 0;
        @(posedge clk); #2;
        q1.push_back(16'd3); q1.push_back(16'd5);
        q2.push_back(16'd4); q2.push_back(16'd10);
        wait_pushes(2, 30, "pair");
        chk("pair_first", 32'(push_log[0]), 7);
        chk("pair_second", 32'(push_log[1]), 15);
        chk("pair_count", 32'(bus.tokens_count), 2);
        chk("pair_rd_pulses", 32'(rd_pulses), 2);

        // One queue empty for a while: no pops until both have data
        push_log.delete(); rd_pulses = 0;
        @(posedge clk); #2 q1.push_back(16'd9);
        repeat (6) @(posedge clk);
        #3 chk("starve_no_rd", 32'(rd_pulses), 0);
        #0 q2.push_back(16'd1);
        wait_pushes(1, 20, "starve");
        chk("starve_sum", 32'(push_log[0]), 10);
        chk("starve_count", 32'(bus.tokens_count), 3);

        // Output queue full for 5 cycles while holding 0x0020
        push_log.delete(); rd_pulses = 0;
        @(posedge clk); #1 bus.full_out = 1'b1;
        push_pair(16'h0010, 16'h0010);
        wait_busy(20, "full");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #3;
            chk("full_out_stable", 32'(bus.output_1), 32'h20);
            chk("full_wr_low", 32'(bus.wr_1), 0);
        end
        chk("full_no_push", 32'(push_log.size()), 0);
        chk("full_one_pop", 32'(rd_pulses), 1);
        @(posedge clk); #1 bus.full_out = 1'b0;
        #3 chk("full_release_wr", 32'(bus.wr_1), 1);
        wait_pushes(1, 10, "full");
        chk("full_sum", 32'(push_log[0]), 32'h20);
        chk("full_count_wrap", 32'(bus.tokens_count), 0);

        // Truncating sum
        push_log.delete();
        push_pair(16'hFFFF, 16'h0003);
        wait_pushes(1, 20, "ovf");
        chk("ovf_sum", 32'(push_log[0]), 32'h0002);

        // Counter wrap with a 2-bit counter
        do_reset();
        push_log.delete(); cnt_log.delete();
        @(posedge clk); #2;
        for (int i = 1; i <= 5; i++) begin
            q1.push_back(16'(i));
            q2.push_back(16'd1);
        end
        wait_pushes(5, 40, "wrap");
        repeat (2) @(posedge clk);
        #3 chk("wrap_len", 32'(cnt_log.size()), 5);
        if (cnt_log.size() == 5) begin
            chk("wrap_c0", 32'(cnt_log[0]), 1);
            chk("wrap_c1", 32'(cnt_log[1]), 2);
            chk("wrap_c2", 32'(cnt_log[2]), 3);
            chk("wrap_c3", 32'(cnt_log[3]), 0);
            chk("wrap_c4", 32'(cnt_log[4]), 1);
        end
        chk("wrap_last_sum", 32'(push_log[4]), 6);

        // Asynchronous reset while holding a blocked sum
        push_log.delete();
        @(posedge clk); #1 bus.full_out = 1'b1;
        push_pair(16'h0100, 16'h0023);
        wait_busy(20, "areset");
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        chk("areset_output_1", 32'(bus.output_1), 0);
        chk("areset_busy", 32'(bus.busy), 0);
        chk("areset_wr_1", 32'(bus.wr_1), 0);
        chk("areset_count", 32'(bus.tokens_count), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        bus.full_out = 1'b0;
        repeat (6) @(posedge clk);
        #3 chk("areset_no_push", 32'(push_log.size()), 0);
        chk("areset_idle", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
